// File: rtl/rs_pkg.sv
// Shared sizing, field polynomial and generator coefficients for the KP4 RS(544,514) encoder.
// Pure constants and elaboration-time helpers; no clocked logic and no latency.
// No handshake of its own; consumers apply their own flow control.
package rs_pkg;

    localparam int SYM_W   = 10;
    localparam int RS_N    = 544;
    localparam int RS_K    = 514;
    localparam int RS_NPAR = 30;
    localparam int CNT_W   = $clog2(RS_N);

    // x^10 + x^3 + 1
    localparam logic [SYM_W:0] PRIM_POLY = 11'h409;

    // Symbol-counter positions of the final message symbol and the final parity symbol
    localparam logic [CNT_W-1:0] CNT_LAST_DATA = CNT_W'(RS_K - 1);
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(RS_N - 1);

    typedef logic [SYM_W-1:0] sym_t;
    typedef logic [RS_NPAR-1:0][SYM_W-1:0] gen_t;

    // Shift-and-add multiply in GF(2^10), reducing by the primitive polynomial each step
    function automatic sym_t gf_mul_f(input sym_t a, input sym_t b);
        sym_t acc;
        sym_t aa;
        acc = '0;
        aa  = a;
        for (int i = 0; i < SYM_W; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = {aa[SYM_W-2:0], 1'b0} ^ (aa[SYM_W-1] ? PRIM_POLY[SYM_W-1:0] : '0);
        end
        return acc;
    endfunction

    // Expand g(x) = prod_{i=0..29} (x - alpha^i); the monic x^30 term is implied
    function automatic gen_t calc_gen();
        logic [RS_NPAR:0][SYM_W-1:0] g;
        sym_t root;
        gen_t res;
        g    = '0;
        g[0] = sym_t'(1);
        root = sym_t'(1);
        for (int i = 0; i < RS_NPAR; i++) begin
            for (int j = RS_NPAR; j > 0; j--) begin
                g[j] = g[j-1] ^ gf_mul_f(root, g[j]);
            end
            g[0] = gf_mul_f(root, g[0]);
            root = gf_mul_f(root, sym_t'(2));
        end
        for (int j = 0; j < RS_NPAR; j++) res[j] = g[j];
        return res;
    endfunction

    localparam gen_t GEN_COEF = calc_gen();

endpackage

// File: rtl/gf_mul.sv
// GF(2^10) multiplier, general operands (used here with one constant operand per instance).
// Purely combinational, zero latency.
// No handshake; the result follows the inputs.
module gf_mul
    import rs_pkg::*;
(
    input  logic [SYM_W-1:0] a,
    input  logic [SYM_W-1:0] b,
    output logic [SYM_W-1:0] p
);

    // Product reduced modulo the primitive polynomial
    always_comb begin
        p = gf_mul_f(a, b);
    end

endmodule

// File: rtl/rs_enc_kp4.sv
// Systematic RS(544,514) encoder: message symbols pass straight through, then 30 parity symbols follow.
// Zero latency in DATA (combinational pass-through); parity emitted immediately after symbol 513.
// Backpressure: m_ready stalls everything; in DATA s_ready mirrors m_ready, in PARITY s_ready is low.
module rs_enc_kp4
    import rs_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [SYM_W-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [SYM_W-1:0] m_data,
    output logic             m_parity,
    output logic             m_last,
    output logic             len_err
);

    typedef enum logic {
        ST_DATA,
        ST_PARITY
    } state_t;

    state_t                         state_q;
    state_t                         state_d;
    logic [CNT_W-1:0]               cnt_q;
    logic [RS_NPAR-1:0][SYM_W-1:0]  par_q;
    logic [RS_NPAR-1:0][SYM_W-1:0]  prod;
    logic [SYM_W-1:0]               fb;
    logic                           load_sym;
    logic                           shift_par;
    logic                           err_d;

    assign fb = s_data ^ par_q[RS_NPAR-1];

    // One constant-coefficient multiplier per generator tap
    for (genvar j = 0; j < RS_NPAR; j++) begin : g_tap
        gf_mul u_mul (
            .a (fb),
            .b (GEN_COEF[j]),
            .p (prod[j])
        );
    end

    // Next state, handshake and output muxing; s_last only feeds the framing check
    always_comb begin
        state_d   = state_q;
        s_ready   = m_ready;
        m_valid   = s_valid;
        m_data    = s_data;
        m_parity  = 1'b0;
        m_last    = 1'b0;
        load_sym  = 1'b0;
        shift_par = 1'b0;
        unique case (state_q)
            ST_DATA: begin
                if (s_valid && m_ready) begin
                    load_sym = 1'b1;
                    if (cnt_q == CNT_LAST_DATA) state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                s_ready  = 1'b0;
                m_valid  = 1'b1;
                m_data   = par_q[RS_NPAR-1];
                m_parity = 1'b1;
                m_last   = (cnt_q == CNT_LAST);
                if (m_ready) begin
                    shift_par = 1'b1;
                    if (cnt_q == CNT_LAST) state_d = ST_DATA;
                end
            end
            default: state_d = ST_DATA;
        endcase
        err_d = load_sym && (s_last != (cnt_q == CNT_LAST_DATA));
    end

    // State, position counter, parity LFSR and the registered framing-error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_DATA;
            cnt_q   <= '0;
            par_q   <= '0;
            len_err <= 1'b0;
        end else begin
            state_q <= state_d;
            len_err <= err_d;
            if (load_sym) begin
                par_q[0] <= prod[0];
                for (int j = 1; j < RS_NPAR; j++) begin
                    par_q[j] <= par_q[j-1] ^ prod[j];
                end
                cnt_q <= cnt_q + 1'b1;
            end else if (shift_par) begin
                // Shifting zeros in leaves the register clear for the next codeword
                par_q <= {par_q[RS_NPAR-2:0], SYM_W'(0)};
                cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rs_enc_kp4.sv
module tb_rs_enc_kp4;
    import rs_pkg::*;

    logic       clk;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [9:0] s_data;
    logic       s_last;
    logic       m_valid;
    logic       m_ready;
    logic [9:0] m_data;
    logic       m_parity;
    logic       m_last;
    logic       len_err;

    rs_enc_kp4 dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_parity (m_parity),
        .m_last   (m_last),
        .len_err  (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] dat;
        logic       par;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    int    exp_err = 0;
    int    err_seen = 0;
    int    beat_no = 0;

    // Field arithmetic via exp/log tables
    int gexp[0:2047];
    int glog[0:1023];
    int tg[0:30];
    logic [9:0] msg[0:513];
    logic       lastv[0:513];
    int exp_par[0:29];
    int obs[0:543];
    int obs_n = 0;

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[glog[a] + glog[b]];
    endfunction

    function automatic void build_field();
        int e;
        e = 1;
        for (int i = 0; i < 1023; i++) begin
            gexp[i] = e;
            gexp[i + 1023] = e;
            glog[e] = i;
            e = e << 1;
            if (e >= 1024) e = e ^ 1033;
        end
        glog[0] = 0;
        for (int j = 0; j <= 30; j++) tg[j] = 0;
        tg[0] = 1;
        for (int i = 0; i < 30; i++) begin
            for (int j = 30; j > 0; j--) tg[j] = tg[j-1] ^ gmul(gexp[i], tg[j]);
            tg[0] = gmul(gexp[i], tg[0]);
        end
    endfunction

    // Parity = m(x) * x^30 mod g(x), by polynomial long division; exp_par[0] is sent first
    function automatic void ref_encode();
        int r[0:543];
        int c;
        for (int d = 0; d < 544; d++) r[d] = 0;
        for (int i = 0; i < 514; i++) r[543 - i] = int'(msg[i]);
        for (int d = 543; d >= 30; d--) begin
            c = r[d];
            if (c != 0) begin
                for (int j = 0; j <= 30; j++) r[d - 30 + j] = r[d - 30 + j] ^ gmul(c, tg[j]);
            end
        end
        for (int k = 0; k < 30; k++) exp_par[k] = r[29 - k];
    endfunction

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Monitor: pop scoreboard on every output handshake; syndrome-check each finished codeword
    always @(negedge clk) begin
        int s;
        logic bad;
        beat_t e;
        if (len_err) err_seen++;
        if (rst) begin
            obs_n = 0;
        end else if (m_valid && m_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL beat %0d: unexpected output dat=%h par=%b last=%b", beat_no, m_data, m_parity, m_last);
            end else begin
                e = exp_q.pop_front();
                if (m_data !== e.dat || m_parity !== e.par || m_last !== e.last) begin
                    fails++;
                    $display("FAIL beat %0d: got dat=%h par=%b last=%b, expected dat=%h par=%b last=%b",
                             beat_no, m_data, m_parity, m_last, e.dat, e.par, e.last);
                end
            end
            beat_no++;
            if (obs_n < 544) obs[obs_n] = int'(m_data);
            obs_n++;
            if (m_last) begin
                bad = (obs_n != 544);
                for (int i = 0; i < 30 && !bad; i++) begin
                    s = 0;
                    for (int k = 0; k < 544; k++) s = gmul(s, gexp[i]) ^ obs[k];
                    if (s != 0) bad = 1'b1;
                end
                tests++;
                if (bad) begin
                    fails++;
                    $display("FAIL syndrome: codeword of %0d symbols has nonzero syndrome, expected 544 with all zero", obs_n);
                end
                obs_n = 0;
            end
        end
    end

    // Send the first n_send symbols of msg; full codewords also wait for all 30 parity beats
    task automatic send_cw(input int n_send, input bit gaps, output int cycles);
        int idx;
        int pcnt;
        idx = 0;
        pcnt = 0;
        cycles = 0;
        ref_encode();
        for (int i = 0; i < n_send; i++) begin
            exp_q.push_back({msg[i], 1'b0, 1'b0});
            if (lastv[i] != (i == 513)) exp_err++;
        end
        if (n_send == 514) begin
            for (int k = 0; k < 30; k++) exp_q.push_back({10'(exp_par[k]), 1'b1, (k == 29)});
        end
        while (!(idx == n_send && (n_send < 514 || pcnt == 30))) begin
            @(posedge clk);
            #1;
            if (idx < n_send) begin
                s_valid = !gaps || ($urandom_range(0, 3) != 0);
                s_data  = msg[idx];
                s_last  = lastv[idx];
            end else begin
                // Symbol offered during parity must be ignored
                s_valid = gaps && ($urandom_range(0, 1) != 0);
                s_data  = 10'($urandom);
                s_last  = 1'b0;
            end
            m_ready = !gaps || ($urandom_range(0, 3) != 0);
            @(negedge clk);
            cycles++;
            if (idx < n_send && s_valid && s_ready) idx++;
            if (m_valid && m_ready && m_parity) pcnt++;
            if (cycles > 20000) begin
                tests++;
                fails++;
                $display("FAIL timeout: codeword stalled at symbol %0d parity %0d", idx, pcnt);
                break;
            end
        end
    endtask

    task automatic fill_msg(input int kind);
        for (int i = 0; i < 514; i++) begin
            msg[i]   = (kind == 0) ? 10'd0 : 10'($urandom);
            lastv[i] = (i == 513);
        end
        if (kind == 1) msg[513] = 10'd1;
        if (kind == 1) for (int i = 0; i < 513; i++) msg[i] = 10'd0;
    endtask

    task automatic check_errs(input string name);
        chk(name, err_seen, exp_err);
    endtask

    initial begin
        int cyc;
        int total;
        build_field();
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = 10'd0;
        s_last = 1'b0;
        m_ready = 1'b0;
        #2;
        chk("rst_m_valid_lo", int'(m_valid), 0);
        chk("rst_len_err", int'(len_err), 0);
        s_valid = 1'b1;
        s_data  = 10'h155;
        m_ready = 1'b1;
        #1;
        chk("rst_m_valid_hi", int'(m_valid), 1);
        chk("rst_s_ready", int'(s_ready), 1);
        chk("rst_m_data", int'(m_data), 'h155);
        chk("rst_m_parity", int'(m_parity), 0);
        chk("rst_m_last", int'(m_last), 0);
        s_valid = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // All-zero message
        fill_msg(0);
        send_cw(514, 1'b0, cyc);
        chk("zero_cw_cycles", cyc, 544);
        check_errs("len_err_zero");

        // Single 1 in the lowest-degree position: parity is g(x) low coefficients
        fill_msg(1);
        send_cw(514, 1'b0, cyc);
        check_errs("len_err_unit");

        // Random messages with random gaps on both sides
        for (int n = 0; n < 3; n++) begin
            fill_msg(2);
            send_cw(514, 1'b1, cyc);
        end
        check_errs("len_err_random");

        // Three back-to-back codewords, continuous flow
        total = 0;
        for (int n = 0; n < 3; n++) begin
            fill_msg(2);
            send_cw(514, 1'b0, cyc);
            total += cyc;
        end
        chk("b2b_cycles", total, 1632);

        // Reset after 200 symbols, then a fresh all-zero codeword
        fill_msg(2);
        send_cw(200, 1'b1, cyc);
        @(posedge clk);
        #1;
        rst = 1'b1;
        s_valid = 1'b1;
        m_ready = 1'b0;
        #1;
        chk("midrst_m_valid", int'(m_valid), 1);
        chk("midrst_s_ready", int'(s_ready), 0);
        chk("midrst_m_parity", int'(m_parity), 0);
        chk("midrst_len_err", int'(len_err), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        s_valid = 1'b0;
        fill_msg(0);
        send_cw(514, 1'b1, cyc);
        check_errs("len_err_after_rst");

        // s_last early on symbol 100 (also correct at 513): one framing error, data unaffected
        fill_msg(2);
        lastv[100] = 1'b1;
        send_cw(514, 1'b1, cyc);
        check_errs("len_err_early_last");

        // s_last never asserted: error reported at symbol 513
        fill_msg(2);
        lastv[513] = 1'b0;
        send_cw(514, 1'b0, cyc);
        check_errs("len_err_missing_last");

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
